// File: rtl/turfio_cin_align_if.sv
// CIN lane alignment bus: start/status toward SURF registers plus lane delay control/readback.
interface turfio_cin_align_if;
    logic       start_i;
    logic [3:0] data_i;
    logic [8:0] delay_cntvalueout_i;
    logic       en_vtc_o;
    logic       delay_load_o;
    logic       delay_rd_o;
    logic [1:0] delay_sel_o;
    logic [8:0] delay_cntvaluein_o;
    logic       busy_o;
    logic       done_o;
    logic       fail_o;
    logic [9:0] eye_start_o;
    logic [9:0] eye_width_o;

    // Register/lane side: issues start, supplies lane data and readback.
    modport master (
        output start_i, data_i, delay_cntvalueout_i,
        input  en_vtc_o, delay_load_o, delay_rd_o, delay_sel_o, delay_cntvaluein_o,
        input  busy_o, done_o, fail_o, eye_start_o, eye_width_o
    );

    // Alignment controller side.
    modport slave (
        input  start_i, data_i, delay_cntvalueout_i,
        output en_vtc_o, delay_load_o, delay_rd_o, delay_sel_o, delay_cntvaluein_o,
        output busy_o, done_o, fail_o, eye_start_o, eye_width_o
    );
endinterface

// File: rtl/turfio_cin_align.sv
// Eye-centering controller for one CIN lane: sweep taps, pick longest passing window, load its centre.
// Define CIN_ALIGN_ODELAY_EN to sweep the IDELAY+ODELAY cascade (1023 combined taps).
module turfio_cin_align #(
    parameter logic [3:0]  TRAIN_PATTERN = 4'hA,
    parameter int unsigned DWELL         = 256,
    parameter int unsigned SETTLE        = 16,
    parameter int unsigned MIN_EYE       = 8
) (
    input logic                rxclk_i,
    input logic                rst_n_i,
    turfio_cin_align_if.slave  cin
);

`ifdef CIN_ALIGN_ODELAY_EN
    localparam logic [9:0] TAP_MAX = 10'd1022;
`else
    localparam logic [9:0] TAP_MAX = 10'd511;
`endif
    localparam logic [8:0] SETTLE_LAST = 9'(SETTLE - 1);
    localparam logic [8:0] DWELL_LAST  = 9'(DWELL - 1);
    localparam logic [9:0] MIN_EYE_W   = 10'(MIN_EYE);

    typedef enum logic [3:0] {
        S_IDLE, S_VTC_OFF, S_ZERO_OD, S_LOAD, S_SETTLE, S_SAMPLE, S_NEXT, S_EVAL,
        S_CTR_LOAD, S_CTR_WAIT, S_READBACK, S_VTC_ON, S_DONE, S_FAIL_LOAD
    } state_t;

    state_t     state, state_n;
    logic [8:0] cnt;
    logic [9:0] tap, centre;
    logic       pass_acc, run_open;
    logic [9:0] run_start, run_len, best_start, best_len;
    logic       done_r, fail_r;
    logic [9:0] eye_start_r, eye_width_r;

    function automatic logic [8:0] idelay_part(input logic [9:0] t);
        return (t > 10'd511) ? 9'd511 : t[8:0];
    endfunction

`ifdef CIN_ALIGN_ODELAY_EN
    function automatic logic [8:0] odelay_part(input logic [9:0] t);
        return (t > 10'd511) ? 9'(t - 10'd511) : '0;
    endfunction
`endif

    // Run bookkeeping for the tap just sampled; a pass on the last tap closes the run too.
    logic       last_tap, cand_valid;
    logic [9:0] cur_start, cur_len, cand_start, cand_len;
    always_comb begin
        last_tap   = (tap == TAP_MAX);
        cur_start  = run_open ? run_start : tap;
        cur_len    = run_open ? run_len + 10'd1 : 10'd1;
        cand_valid = pass_acc ? last_tap : run_open;
        cand_start = pass_acc ? cur_start : run_start;
        cand_len   = pass_acc ? cur_len : run_len;
    end

    always_ff @(posedge rxclk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (cin.start_i) state_n = S_VTC_OFF;
            S_VTC_OFF:  if (cnt == SETTLE_LAST) state_n = S_ZERO_OD;
            S_ZERO_OD:  state_n = S_LOAD;
            S_LOAD:     state_n = S_SETTLE;
            S_SETTLE:   if (cnt == SETTLE_LAST) state_n = S_SAMPLE;
            S_SAMPLE:   if (cnt == DWELL_LAST) state_n = S_NEXT;
            S_NEXT:     state_n = last_tap ? S_EVAL : S_LOAD;
            S_EVAL:     state_n = (best_len < MIN_EYE_W) ? S_FAIL_LOAD : S_CTR_LOAD;
`ifdef CIN_ALIGN_ODELAY_EN
            S_CTR_LOAD: if (cnt == 9'd1) state_n = S_CTR_WAIT;
`else
            S_CTR_LOAD: state_n = S_CTR_WAIT;
`endif
            S_CTR_WAIT: if (cnt == SETTLE_LAST) state_n = S_READBACK;
            S_READBACK: if (cnt == 9'd2)
                            state_n = (cin.delay_cntvalueout_i == idelay_part(centre)) ? S_VTC_ON
                                                                                       : S_FAIL_LOAD;
            S_VTC_ON:   if (cnt == SETTLE_LAST) state_n = S_DONE;
            S_DONE:     state_n = S_IDLE;
            S_FAIL_LOAD: state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge rxclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0; tap <= '0; centre <= '0; pass_acc <= 1'b0; run_open <= 1'b0;
            run_start <= '0; run_len <= '0; best_start <= '0; best_len <= '0;
            done_r <= 1'b0; fail_r <= 1'b0; eye_start_r <= '0; eye_width_r <= '0;
        end else begin
            cnt <= (state_n != state) ? '0 : cnt + 9'd1;
            case (state)
                S_IDLE: if (cin.start_i) begin
                    tap <= '0; run_open <= 1'b0; run_start <= '0; run_len <= '0;
                    best_start <= '0; best_len <= '0;
                    done_r <= 1'b0; fail_r <= 1'b0; eye_start_r <= '0; eye_width_r <= '0;
                end
                S_LOAD:   pass_acc <= 1'b1;
                S_SAMPLE: if (cin.data_i != TRAIN_PATTERN) pass_acc <= 1'b0;
                S_NEXT: begin
                    if (pass_acc) begin
                        run_start <= cur_start;
                        run_len   <= cur_len;
                    end
                    run_open <= pass_acc && !last_tap;
                    if (cand_valid && cand_len > best_len) begin
                        best_start <= cand_start;
                        best_len   <= cand_len;
                    end
                    if (!last_tap) tap <= tap + 10'd1;
                end
                S_EVAL: begin
                    eye_start_r <= best_start;
                    eye_width_r <= best_len;
                    centre      <= best_start + (best_len >> 1);
                end
                S_DONE:      done_r <= 1'b1;
                S_FAIL_LOAD: fail_r <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cin.delay_load_o       = 1'b0;
        cin.delay_rd_o         = 1'b0;
        cin.delay_sel_o        = 2'd0;
        cin.delay_cntvaluein_o = '0;
        cin.en_vtc_o           = 1'b1;
        cin.busy_o             = !(state inside {S_IDLE, S_DONE, S_FAIL_LOAD});
        if (state inside {S_VTC_OFF, S_ZERO_OD, S_LOAD, S_SETTLE, S_SAMPLE, S_NEXT, S_EVAL,
                          S_CTR_LOAD, S_CTR_WAIT, S_READBACK})
            cin.en_vtc_o = 1'b0;
        case (state)
            S_ZERO_OD: begin
                cin.delay_load_o = 1'b1;
                cin.delay_sel_o  = 2'd1;
            end
            S_LOAD: begin
                cin.delay_load_o = 1'b1;
`ifdef CIN_ALIGN_ODELAY_EN
                // Beyond IDELAY end-stop only the ODELAY stage moves.
                if (tap > 10'd511) begin
                    cin.delay_sel_o        = 2'd1;
                    cin.delay_cntvaluein_o = odelay_part(tap);
                end else begin
                    cin.delay_cntvaluein_o = tap[8:0];
                end
`else
                cin.delay_cntvaluein_o = tap[8:0];
`endif
            end
            S_CTR_LOAD: begin
                cin.delay_load_o = 1'b1;
`ifdef CIN_ALIGN_ODELAY_EN
                if (cnt == 9'd0) begin
                    cin.delay_cntvaluein_o = idelay_part(centre);
                end else begin
                    cin.delay_sel_o        = 2'd1;
                    cin.delay_cntvaluein_o = odelay_part(centre);
                end
`else
                cin.delay_cntvaluein_o = idelay_part(centre);
`endif
            end
            S_READBACK:  cin.delay_rd_o   = (cnt == 9'd0);
            S_FAIL_LOAD: cin.delay_load_o = 1'b1;
            default: ;
        endcase
    end

    assign cin.done_o      = done_r;
    assign cin.fail_o      = fail_r;
    assign cin.eye_start_o = eye_start_r;
    assign cin.eye_width_o = eye_width_r;

endmodule
